// File: rtl/tap_transposed_mc.sv
// Multi-channel transposed FIR tap.
// Two-stage pipeline with a per-channel coefficient bank.
module tap_transposed_mc #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int FRAC_BITS  = 23,
  parameter int NUM_CH     = 2,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [CW-1:0]         iv_ch,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic [DATA_WIDTH-1:0] iv_sum,
  input  logic                  i_coef_wr,
  input  logic [CW-1:0]         iv_coef_addr,
  input  logic [COEF_WIDTH-1:0] iv_coef,
  input  logic                  i_ovf_clr,
  output logic                  o_valid,
  output logic [CW-1:0]         ov_ch,
  output logic [DATA_WIDTH-1:0] ov_sum,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_ovf
);

  localparam int PW  = DATA_WIDTH + COEF_WIDTH;
  localparam int FW  = PW + 2;
  localparam int RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic [CW:0] NCH = (CW+1)'(NUM_CH);
  localparam logic signed [PW:0] ONE = 1;
  localparam logic signed [PW:0] RND =
    (ROUND != 0 && FRAC_BITS > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [FW-1:0] MAXV =
    {{(FW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] MINV =
    {{(FW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [COEF_WIDTH-1:0] coef_q [NUM_CH];
  logic signed [COEF_WIDTH-1:0] coef_d;

  logic signed [PW-1:0]         prod_q;
  logic signed [PW-1:0]         prod_d;
  logic [DATA_WIDTH-1:0]        din1_q;
  logic [DATA_WIDTH-1:0]        sum1_q;
  logic [CW-1:0]                ch1_q;
  logic                         v1_q;

  logic signed [PW:0]           rsum_d;
  logic signed [PW:0]           scaled_d;
  logic signed [FW-1:0]         full_d;
  logic                         ovf_d;
  logic [DATA_WIDTH-1:0]        res_d;

  logic                         valid_q;
  logic [CW-1:0]                ch_q;
  logic [DATA_WIDTH-1:0]        sum_q;
  logic [DATA_WIDTH-1:0]        dout_q;
  logic                         ovf_q;

  // Coefficient write port; out-of-range addresses are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) coef_q[i] <= '0;
    end else if (i_coef_wr && ({1'b0, iv_coef_addr} < NCH)) begin
      coef_q[iv_coef_addr] <= iv_coef;
    end
  end

  // Coefficient lookup and full-width product for stage 1.
  always_comb begin
    coef_d = coef_q[0];
    if ({1'b0, iv_ch} < NCH) coef_d = coef_q[iv_ch];
    prod_d = {{COEF_WIDTH{iv_din[DATA_WIDTH-1]}}, iv_din}
           * {{DATA_WIDTH{coef_d[COEF_WIDTH-1]}}, coef_d};
  end

  // Stage 1: product plus sample, partial sum and tags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod_q <= '0;
      din1_q <= '0;
      sum1_q <= '0;
      ch1_q  <= '0;
      v1_q   <= 1'b0;
    end else if (i_en) begin
      prod_q <= prod_d;
      din1_q <= iv_din;
      sum1_q <= iv_sum;
      ch1_q  <= iv_ch;
      v1_q   <= i_valid;
    end
  end

  // Round, scale, accumulate and range-limit the stage-1 result.
  always_comb begin
    rsum_d   = {prod_q[PW-1], prod_q} + RND;
    scaled_d = rsum_d >>> FRAC_BITS;
    full_d   = {{(FW-PW-1){scaled_d[PW]}}, scaled_d}
             + {{(FW-DATA_WIDTH){sum1_q[DATA_WIDTH-1]}}, sum1_q};
    ovf_d    = (full_d > MAXV) || (full_d < MINV);
    res_d    = full_d[DATA_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (full_d > MAXV) res_d = MAXV[DATA_WIDTH-1:0];
      else if (full_d < MINV) res_d = MINV[DATA_WIDTH-1:0];
    end
  end

  // Stage 2: registered outputs aligned to the result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      sum_q   <= '0;
      dout_q  <= '0;
    end else if (i_en) begin
      valid_q <= v1_q;
      ch_q    <= ch1_q;
      sum_q   <= res_d;
      dout_q  <= din1_q;
    end
  end

  // Sticky overflow: a counted overflow beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (i_en && v1_q && ovf_d) begin
      ovf_q <= 1'b1;
    end else if (i_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign ov_ch   = ch_q;
  assign ov_sum  = sum_q;
  assign ov_dout = dout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_tap_transposed_mc.sv
// Directed bench for tap_transposed_mc.
// Instance a rounds/saturates, instance b truncates/wraps.
module tb_tap_transposed_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       valid;
  logic [0:0] ch;
  logic [7:0] din;
  logic [7:0] sum;
  logic       coef_wr;
  logic [0:0] coef_addr;
  logic [7:0] coef;
  logic       ovf_clr;

  logic       a_valid, b_valid;
  logic [0:0] a_ch, b_ch;
  logic [7:0] a_sum, b_sum;
  logic [7:0] a_dout, b_dout;
  logic       a_ovf, b_ovf;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  tap_transposed_mc #(
    .DATA_WIDTH(8), .COEF_WIDTH(8), .FRAC_BITS(7),
    .NUM_CH(2), .ROUND(1), .SATURATE(1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid),
    .iv_ch(ch), .iv_din(din), .iv_sum(sum),
    .i_coef_wr(coef_wr), .iv_coef_addr(coef_addr),
    .iv_coef(coef), .i_ovf_clr(ovf_clr),
    .o_valid(a_valid), .ov_ch(a_ch), .ov_sum(a_sum),
    .ov_dout(a_dout), .o_ovf(a_ovf)
  );

  tap_transposed_mc #(
    .DATA_WIDTH(8), .COEF_WIDTH(8), .FRAC_BITS(7),
    .NUM_CH(2), .ROUND(0), .SATURATE(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid),
    .iv_ch(ch), .iv_din(din), .iv_sum(sum),
    .i_coef_wr(coef_wr), .iv_coef_addr(coef_addr),
    .iv_coef(coef), .i_ovf_clr(ovf_clr),
    .o_valid(b_valid), .ov_ch(b_ch), .ov_sum(b_sum),
    .ov_dout(b_dout), .o_ovf(b_ovf)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [0:0] c,
                     input int d, input int s);
    valid = v;
    ch    = c;
    din   = 8'(d);
    sum   = 8'(s);
  endtask

  task automatic wcoef(input logic [0:0] a, input int c);
    coef_wr   = 1'b1;
    coef_addr = a;
    coef      = 8'(c);
    tick();
    coef_wr   = 1'b0;
  endtask

  function automatic logic signed [31:0] s8(input logic [7:0] x);
    return 32'($signed(x));
  endfunction

  function automatic logic signed [31:0] u1(input logic x);
    return 32'(x);
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b1; ovf_clr = 1'b0;
    coef_wr = 1'b0; coef_addr = '0; coef = '0;
    put(1'b0, 1'b0, 0, 0);
    tick(); tick();
    chk("rst_valid", u1(a_valid), 0);
    chk("rst_sum", s8(a_sum), 0);
    chk("rst_ovf", u1(a_ovf), 0);
    rst_n = 1'b1;
    tick();

    // basic two-channel operation
    wcoef(1'b0, 64);
    wcoef(1'b1, -64);
    put(1'b1, 1'b0, 64, 10);
    tick();
    put(1'b1, 1'b1, 64, 10);
    tick();
    chk("t1_a_sum0", s8(a_sum), 42);
    chk("t1_a_ch0", u1(a_ch), 0);
    chk("t1_a_v0", u1(a_valid), 1);
    chk("t1_a_dout0", s8(a_dout), 64);
    chk("t1_b_sum0", s8(b_sum), 42);
    put(1'b0, 1'b0, 0, 0);
    tick();
    chk("t1_a_sum1", s8(a_sum), -22);
    chk("t1_a_ch1", u1(a_ch), 1);
    chk("t1_b_sum1", s8(b_sum), -22);
    chk("t1_a_dout1", s8(a_dout), 64);
    tick();
    chk("t1_a_v2", u1(a_valid), 0);

    // rounding versus truncation
    put(1'b1, 1'b0, 3, 0);
    tick();
    put(1'b1, 1'b0, -3, 0);
    tick();
    chk("t2_a_p3", s8(a_sum), 2);
    chk("t2_b_p3", s8(b_sum), 1);
    put(1'b0, 1'b0, 0, 0);
    tick();
    chk("t2_a_m3", s8(a_sum), -1);
    chk("t2_b_m3", s8(b_sum), -2);

    // saturation versus wrap
    wcoef(1'b0, -128);
    wcoef(1'b1, 64);
    chk("t3_ovf_pre", u1(a_ovf), 0);
    put(1'b1, 1'b0, -128, 0);
    tick();
    put(1'b1, 1'b1, -128, -100);
    tick();
    chk("t3_a_hi", s8(a_sum), 127);
    chk("t3_b_hi", s8(b_sum), -128);
    chk("t3_a_ovf", u1(a_ovf), 1);
    chk("t3_b_ovf", u1(b_ovf), 1);
    put(1'b1, 1'b0, 1, 0);
    tick();
    chk("t3_a_lo", s8(a_sum), -128);
    chk("t3_b_lo", s8(b_sum), 92);
    put(1'b0, 1'b0, 0, 0);
    tick();
    chk("t4_a_nov", s8(a_sum), -1);
    chk("t4_a_sticky", u1(a_ovf), 1);

    // overflow clear behaviour
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_a_clr", u1(a_ovf), 0);
    chk("t4_b_clr", u1(b_ovf), 0);
    put(1'b0, 1'b0, -128, 0);
    tick(); tick();
    chk("t4_inv_a", u1(a_ovf), 0);
    chk("t4_inv_b", u1(b_ovf), 0);
    chk("t4_inv_v", u1(a_valid), 0);
    put(1'b1, 1'b0, -128, 0);
    tick();
    put(1'b0, 1'b0, 0, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_setwin_a", u1(a_ovf), 1);
    chk("t4_setwin_b", u1(b_ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_clr2", u1(a_ovf), 0);

    // stall with changing inputs
    wcoef(1'b0, 64);
    wcoef(1'b1, -64);
    put(1'b1, 1'b0, 64, 10);
    tick();
    put(1'b1, 1'b1, 64, 10);
    tick();
    chk("t5_pre", s8(a_sum), 42);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 1'(i), 100 + i, 50 - i);
      tick();
      chk("t5_hold_sum", s8(a_sum), 42);
      chk("t5_hold_ch", u1(a_ch), 0);
      chk("t5_hold_v", u1(a_valid), 1);
    end
    en = 1'b1;
    put(1'b1, 1'b0, 3, 0);
    tick();
    chk("t5_res1", s8(a_sum), -22);
    chk("t5_res1_ch", u1(a_ch), 1);
    put(1'b0, 1'b0, 0, 0);
    tick();
    chk("t5_res2_a", s8(a_sum), 2);
    chk("t5_res2_b", s8(b_sum), 1);
    tick();
    chk("t5_res3_v", u1(a_valid), 0);

    // coefficient write on the reading edge
    put(1'b1, 1'b0, 64, 0);
    coef_wr = 1'b1; coef_addr = 1'b0; coef = 8'd32;
    tick();
    coef_wr = 1'b0;
    tick();
    chk("t5_oldcoef", s8(a_sum), 32);
    put(1'b0, 1'b0, 0, 0);
    tick();
    chk("t5_newcoef_a", s8(a_sum), 16);
    chk("t5_newcoef_b", s8(b_sum), 16);

    // asynchronous reset mid-stream
    put(1'b1, 1'b0, -128, -100);
    tick();
    put(1'b1, 1'b0, 64, 10);
    tick();
    chk("t6_pre_ovf", u1(a_ovf), 1);
    chk("t6_pre_v", u1(a_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_v", u1(a_valid), 0);
    chk("t6_rst_sum", s8(a_sum), 0);
    chk("t6_rst_dout", s8(a_dout), 0);
    chk("t6_rst_ch", u1(a_ch), 0);
    chk("t6_rst_ovf", u1(a_ovf), 0);
    chk("t6_rst_bovf", u1(b_ovf), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_lat_v", u1(a_valid), 0);
    put(1'b0, 1'b0, 0, 0);
    tick();
    chk("t6_out_v", u1(a_valid), 1);
    chk("t6_bank_a", s8(a_sum), 10);
    chk("t6_bank_b", s8(b_sum), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
